cix32_mem_responder: RTL
========================

// Module: cix32_mem_responder
// PURPOSE
//  Memory-side responder for the CIX-32 LSU data interface (mem_req/mem_we/mem_ready).
//  Word-organised on-chip data RAM with byte strobes and programmable wait states.
//  Sits between the LSU memory port and the data RAM array.
//  Returns one mem_ready pulse per accepted request and flags out-of-range accesses on mem_err.
// PARAMETERS
//  DEPTH        1024  RAM size in 32-bit words; power of two >= 2
//  WAIT_STATES  1     extra cycles between accept and mem_ready; 0..15
// PORTS
//  clk        in   1   clock; all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  mem_addr   in   32  byte address from LSU (physical)
//  mem_wdata  in   32  store data
//  mem_wstrb  in   4   byte write strobes; bit i -> wdata[8i+7:8i]
//  mem_req    in   1   request; held high by LSU until mem_ready seen
//  mem_we     in   1   1 = write, 0 = read
//  mem_rdata  out  32  read data; valid in the mem_ready cycle of a read
//  mem_ready  out  1   one-cycle completion pulse
//  mem_err    out  1   out-of-range flag; valid only with mem_ready
// BEHAVIOUR
//  Reset: mem_ready=0, mem_err=0, mem_rdata=0, state=IDLE, wait counter=0.
//  RAM contents are not reset. Reset mid-transaction aborts the transaction:
//  no write commits and no mem_ready is issued.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: if mem_req=1, latch addr/we/wdata/wstrb and load counter=WAIT_STATES.
//     Go to WAIT if WAIT_STATES>0, else go to RESP.
//   WAIT: decrement counter. Go to RESP in the cycle the counter reaches 0.
//   RESP: mem_ready=1 for exactly this cycle. Next state is IDLE unconditionally.
//     mem_req is ignored in RESP; the LSU still drives it high in this cycle.
//  Latency: req sampled in IDLE at cycle N -> mem_ready at cycle N+1+WAIT_STATES.
//  Inputs are used only as latched in IDLE. Changes on mem_* after acceptance are ignored.
//  Address decode: word index = addr[log2(DEPTH)+1:2]. addr[1:0] is ignored (no misalign fault).
//  Range: addr >= DEPTH*4 -> mem_err=1 in the RESP cycle.
//    On mem_err, writes are suppressed and mem_rdata=32'h0000_0000.
//  Write: commits in the RESP cycle, per-byte under the latched wstrb.
//    wstrb=4'b0000 -> no change, normal mem_ready.
//  Read: mem_rdata = RAM[index] registered, presented in the RESP cycle.
//    mem_rdata holds its value until the next read response; writes do not alter it.
//  A read issued the cycle after a write to the same word returns the new data.
//  Max throughput: one transaction per 2+WAIT_STATES cycles. mem_ready is never asserted
//    unless preceded by an accepted mem_req.
//  mem_err=0 whenever mem_ready=0.
// TESTING
//  1 WAIT_STATES=1: write 0x1234_5678, wstrb=F, addr 0x10; req at cyc 5
//    -> mem_ready at cyc 7 only, err=0.
//  2 Read addr 0x10 -> rdata=0x1234_5678 with ready.
//    Then write wstrb=4'b0010, wdata=0xAAAA_BBCC, read back -> 0x1234_BB78.
//  3 DEPTH=1024: write 0xFFFF_FFFF to addr 0x1000 -> ready+err=1.
//    Read addr 0x0 -> prior value unchanged. Read 0x1000 -> rdata=0, err=1.
//  4 WAIT_STATES=0: hold mem_req high continuously
//    -> ready pulses every 2 cycles, never in consecutive cycles.
//  5 Assert rst for 1 cycle in WAIT of a write to addr 0x20 (old 0x0)
//    -> no ready; a later read of 0x20 returns 0x0.
//  6 addr 0x13 read after writing 0xCAFE_F00D at 0x10 -> rdata=0xCAFE_F00D.
//    Change mem_addr mid-WAIT -> response still reflects the latched address.

Source files
------------

// File: rtl/cix32_mem_responder.sv
// rtl/cix32_mem_responder.sv - CIX-32 LSU data-port responder over a byte-strobed word RAM
module cix32_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        mem_req,
  input  logic        mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WS        = 4'(WAIT_STATES);
  localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [63:0] LIMIT    = 64'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        we_q;

  logic [31:0] ram [DEPTH];

  // Access fields: live inputs when a zero-wait request completes straight from IDLE,
  // otherwise the values captured at acceptance.
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_wstrb;
  logic          acc_we;
  logic          fire;
  logic          oob;
  logic [AW-1:0] idx;

  // Select the access source and detect the cycle whose closing edge enters RESP.
  always_comb begin
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wstrb = wstrb_q;
    acc_we    = we_q;
    fire      = 1'b0;
    if (state == IDLE) begin
      acc_addr  = mem_addr;
      acc_wdata = mem_wdata;
      acc_wstrb = mem_wstrb;
      acc_we    = mem_we;
      fire      = mem_req && ZERO_WAIT;
    end else if (state == WAIT) begin
      fire = (cnt == 4'd1);
    end
    oob = ({32'd0, acc_addr} >= LIMIT);
    idx = acc_addr[AW+1:2];
  end

  // Control FSM with registered response outputs; the RAM is sampled on the edge into RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      we_q      <= 1'b0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            we_q    <= mem_we;
            cnt     <= WS;
            state   <= ZERO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fire) begin
        mem_ready <= 1'b1;
        mem_err   <= oob;
        if (!acc_we) mem_rdata <= oob ? 32'd0 : ram[idx];
      end
    end
  end

  // Byte-strobed write, committed together with the response; reset aborts it.
  always_ff @(posedge clk) begin
    if (!rst && fire && acc_we && !oob) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb[i]) ram[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule
